// File: rtl/mem_arbiter.sv
// mem_arbiter
// -----------------------------------------------------------------------------
// Round-robin arbiter and sequencer that shares one main memory between the
// instruction cache (port 0) and the data cache (port 1).
//
// Handshake (both cache ports): a requester raises reqN with opN/addrN/wdataN
// stable and holds it until ackN. ackN is a one-cycle pulse that marks
// completion. For reads, rdataN is valid in the ack cycle and is held until the
// next ack on that port. The arbiter samples op/addr/wdata only at the grant
// edge. Request changes during ISSUE or DONE are ignored. A timeout aborts the
// access with an err pulse and no ack. The requester keeps req asserted and is
// arbitrated again.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   req0/1, op0/1, addr0/1,     request side (icache = 0, dcache = 1)
//   wdata0/1
//   ack0/1, rdata0/1            completion pulse and returned line
//   err                         one-cycle pulse on timeout abort
//   busy                        state is not IDLE
//   mem_*                       memory enable/op/address/data/op_init/op_done,
//                               data_out and data_ready
//   dbg_state                   current FSM state (IDLE=0, ISSUE=1, DONE=2)
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int CACHE_LINE_SIZE     = 128,
  parameter int MEMORY_ADDRESS_SIZE = 32,
  parameter int TIMEOUT_CYCLES      = 64
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           req0,
  input  logic                           req1,
  input  logic                           op0,
  input  logic                           op1,
  input  logic [MEMORY_ADDRESS_SIZE-1:0] addr0,
  input  logic [MEMORY_ADDRESS_SIZE-1:0] addr1,
  input  logic [CACHE_LINE_SIZE-1:0]     wdata0,
  input  logic [CACHE_LINE_SIZE-1:0]     wdata1,
  output logic                           ack0,
  output logic                           ack1,
  output logic [CACHE_LINE_SIZE-1:0]     rdata0,
  output logic [CACHE_LINE_SIZE-1:0]     rdata1,
  output logic                           err,
  output logic                           busy,
  output logic                           mem_enable,
  output logic                           mem_op,
  output logic [MEMORY_ADDRESS_SIZE-1:0] mem_address,
  output logic [CACHE_LINE_SIZE-1:0]     mem_data_in,
  output logic                           mem_op_init,
  output logic                           mem_op_done,
  input  logic [CACHE_LINE_SIZE-1:0]     mem_data_out,
  input  logic                           mem_data_ready,
  output logic [1:0]                     dbg_state
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                         state_q, state_d;
  logic                           last_q, last_d;
  logic                           grant_q, grant_d;
  logic [CW-1:0]                  cnt_q, cnt_d;
  logic                           en_q, en_d;
  logic                           op_q, op_d;
  logic                           init_q, init_d;
  logic                           done_q, done_d;
  logic                           ack0_q, ack0_d;
  logic                           ack1_q, ack1_d;
  logic                           err_q, err_d;
  logic [MEMORY_ADDRESS_SIZE-1:0] addr_q, addr_d;
  logic [CACHE_LINE_SIZE-1:0]     wdata_q, wdata_d;
  logic [CACHE_LINE_SIZE-1:0]     rdata0_q, rdata0_d;
  logic [CACHE_LINE_SIZE-1:0]     rdata1_q, rdata1_d;

  // Winner: with both requesting, take the port that did not win last time.
  // Otherwise take whichever port is requesting.
  logic win;
  assign win = (req0 & req1) ? ~last_q : req1;

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    grant_d  = grant_q;
    cnt_d    = cnt_q;
    en_d     = en_q;
    op_d     = op_q;
    init_d   = init_q;
    done_d   = done_q;
    ack0_d   = ack0_q;
    ack1_d   = ack1_q;
    err_d    = err_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;

    unique case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          grant_d = win;
          last_d  = win;
          op_d    = win ? op1 : op0;
          addr_d  = win ? addr1 : addr0;
          wdata_d = win ? wdata1 : wdata0;
          en_d    = 1'b1;
          init_d  = 1'b1;
          cnt_d   = '0;
          state_d = ISSUE;
        end
      end

      ISSUE: begin
        init_d = 1'b0;
        // In the first ISSUE cycle, ready may still be left over from the
        // previous access, so it is not trusted then.
        if (mem_data_ready && !init_q) begin
          en_d    = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
          if (grant_q) begin
            ack1_d = 1'b1;
            if (!op_q) rdata1_d = mem_data_out;
          end else begin
            ack0_d = 1'b1;
            if (!op_q) rdata0_d = mem_data_out;
          end
        end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          en_d    = 1'b0;
          done_d  = 1'b1;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      DONE: begin
        done_d  = 1'b0;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        err_d   = 1'b0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      last_q   <= 1'b0;
      grant_q  <= 1'b0;
      cnt_q    <= '0;
      en_q     <= 1'b0;
      op_q     <= 1'b0;
      init_q   <= 1'b0;
      done_q   <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      err_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      grant_q  <= grant_d;
      cnt_q    <= cnt_d;
      en_q     <= en_d;
      op_q     <= op_d;
      init_q   <= init_d;
      done_q   <= done_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      err_q    <= err_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  assign ack0        = ack0_q;
  assign ack1        = ack1_q;
  assign rdata0      = rdata0_q;
  assign rdata1      = rdata1_q;
  assign err         = err_q;
  assign busy        = (state_q != IDLE);
  assign mem_enable  = en_q;
  assign mem_op      = op_q;
  assign mem_address = addr_q;
  assign mem_data_in = wdata_q;
  assign mem_op_init = init_q;
  assign mem_op_done = done_q;
  assign dbg_state   = state_q;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and sequencer for the shared main memory. It sits between the instruction cache (port 0) and the data cache (port 1) on one side and the single `Memory` instance on the other. It grants the memory to one requester at a time, round-robin. It drives the memory's enable/op/address/data, op_init and op_done handshake, and returns the line and a one-cycle acknowledge to the winning cache.

## Interface
- `CACHE_LINE_SIZE`, 128, line width in bits
- `MEMORY_ADDRESS_SIZE`, 32, byte-address width
- `TIMEOUT_CYCLES`, 64, max cycles in ISSUE before abort; must be > memory latency
- `clk` in 1: single clock; all state changes on rising edge
- `rst_n` in 1: reset, asynchronous, active-low
- `req0`, `req1` in 1: request from icache / dcache, held until `ack`
- `op0`, `op1` in 1: 0 read, 1 write
- `addr0`, `addr1` in MEMORY_ADDRESS_SIZE: line address
- `wdata0`, `wdata1` in CACHE_LINE_SIZE: write line
- `ack0`, `ack1` out 1: one-cycle completion pulse
- `rdata0`, `rdata1` out CACHE_LINE_SIZE: read line, valid in `ack` cycle, held until that port's next ack
- `err` out 1: one-cycle pulse on timeout abort
- `busy` out 1: high whenever state is not IDLE
- `mem_enable` out 1: to memory `enable`
- `mem_op` out 1: to memory `op`
- `mem_address` out MEMORY_ADDRESS_SIZE: to memory `address`
- `mem_data_in` out CACHE_LINE_SIZE: to memory `data_in`
- `mem_op_init` out 1: to memory `op_init`
- `mem_op_done` out 1: to memory `op_done`
- `mem_data_out` in CACHE_LINE_SIZE: from memory `data_out`
- `mem_data_ready` in 1: from memory `data_ready`

## Operation
- FSM states and transitions:
  - IDLE: if any `req`, select winner, latch its op/addr/wdata into mem_* registers and go to ISSUE.
  - ISSUE: `mem_enable`=1; exit on `mem_data_ready` or timeout.
  - DONE: one cycle, then IDLE.
- Round-robin arbitration:
  - `last` register, reset to 0.
  - Both requesting: grant port ≠ `last`.
  - Single requester: grant it.
  - `last` updates to the winner at grant.
- Requester rules:
  - `op`/`addr`/`wdata` must be stable while `req`=1.
  - The arbiter samples them only at grant.
  - Request changes during ISSUE/DONE are ignored.
- `mem_op_init`: high exactly in the first ISSUE cycle.
- `mem_data_ready` is ignored in the first ISSUE cycle, which guards against stale ready.
- ISSUE → DONE on `mem_data_ready`=1 (not first cycle).
  - Same edge: `mem_enable`←0, `mem_op_done`←1.
  - Winner's `ack`←1; for reads, winner's `rdata`←`mem_data_out`.
  - Writes leave `rdata` unchanged.
- DONE → IDLE: `mem_op_done`←0, `ack`←0. No new grant is made in DONE.
  - Memory clears `data_ready` on the edge where it samples `op_done`=1.
- `mem_enable` never stays high past the ready cycle, so the memory does not restart an access.
- Timeout:
  - A cycle counter in ISSUE reaching TIMEOUT_CYCLES → DONE with `err`=1 and `mem_op_done`=1.
  - No `ack` is issued; the requester keeps `req` and is re-arbitrated normally.
- `mem_address`, `mem_op`, `mem_data_in` are held constant from grant until IDLE.

## Timing
- Reset values: all outputs 0; `rdata0`/`rdata1` = 0; state IDLE; `last`=0; counter 0.
- `rst_n` low at any time, including mid-ISSUE:
  - Immediately clears all of the above; the transaction is dropped with no `ack`.
  - Requesters must re-request.
- Grant edge G (IDLE samples `req`):
  - `mem_enable`/`mem_op_init` high in cycle G+1.
  - `ack` high in the cycle after the edge that samples `mem_data_ready`.
- Latency with memory delay D = MEMORY_OP_DELAY_CYCLES: `ack` in cycle G+D+4.
  - Memory takes D+2 enabled edges to raise ready; the arbiter needs one more edge to see it.
- Back-to-back: a request held through `ack` is re-granted at the DONE→IDLE+1 edge, giving a 2-cycle gap between transactions.
- Maximum sustained rate: one transaction per D+5 cycles.

## Test plan
- Reset, then single read: `req0`=1, `op0`=0, `addr0`=0x10 with memory preloaded to line 0x00112233..., D=5.
  - Required: `mem_op_init` 1 cycle; `ack0` in cycle G+9 with `rdata0` = preloaded line.
  - `mem_enable` low from the ack cycle; `ack1` never asserted.
- Write then read-back via port 1: write `wdata1`=0xDEADBEEF_... to 0x40, then read 0x40.
  - Required: second `ack1` returns the identical line; `rdata1` unchanged after the write ack.
- Simultaneous requests after reset: `req0`=`req1`=1 held.
  - Required: grants alternate 1,0,1,0 and each `ack` goes to the matching port.
  - `mem_address` equals the granted `addr` for each.
- Request change mid-flight: change `addr0` during ISSUE.
  - Required: `mem_address` keeps the grant-time value; read data comes from the original address.
- Timeout: hold `mem_data_ready`=0 with TIMEOUT_CYCLES=16.
  - Required: `err` pulses once after 16 ISSUE cycles; no `ack`; `mem_op_done` pulses; the request is re-granted.
- Async reset mid-ISSUE: drop `rst_n` at cycle G+3.
  - Required: all outputs 0 immediately, no `ack`.
  - After release with `req` held, a new grant occurs and completes normally.
